// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and bit-timing helper shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
  function automatic int cycles_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with input synchroniser, mid-bit sampling FSM and byte/error strobes
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int cpb = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       busy
);
  localparam int half = cpb / 2;
  localparam int cw = $clog2(cpb);
  logic [1:0] sync_q, sync_d;
  rx_state_t state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic rx_s, bit_end, half_end;
  assign rx_s = sync_q[1];
  assign bit_end = cnt_q == cw'(cpb - 1);
  assign half_end = cnt_q == cw'(half - 1);
  assign rx_byte = shift_q;
  assign busy = state_q != IDLE;
  always_comb begin
    sync_d = {sync_q[0], ser_rx};
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    rx_valid = 1'b0;
    rx_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (half_end) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        shift_d = {rx_s, shift_q[7:1]};
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        cnt_d = '0;
        rx_valid = rx_s;
        rx_ferr = !rx_s;
        state_d = rx_s ? IDLE : BREAK;
      end
      BREAK: state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
    end
  end
endmodule

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: writes received UART bytes to consecutive block_ram addresses with wrap tracking
module uart_ram_loader
  import uart_pkg::*;
#(
  parameter int clock_rate = 24000000,
  parameter int baud_rate = 1200,
  parameter int depth = 1152,
  parameter int addr_bits = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_rx,
  output logic [addr_bits-1:0] waddr,
  output logic [7:0]           wdata,
  output logic                 wren,
  output logic                 frame_err,
  output logic                 wrapped,
  output logic                 busy
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_ferr, last;
  logic [addr_bits-1:0] ptr_q, ptr_d, waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic wren_q, wren_d, ferr_q, ferr_d, wrapped_q, wrapped_d;
  uart_rx_core #(.cpb(cycles_per_bit(clock_rate, baud_rate))) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .ser_rx(ser_rx),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr(rx_ferr),
    .busy(busy)
  );
  assign last = ptr_q == addr_bits'(depth - 1);
  always_comb begin
    wren_d = rx_valid;
    ferr_d = rx_ferr;
    waddr_d = rx_valid ? ptr_q : waddr_q;
    wdata_d = rx_valid ? rx_byte : wdata_q;
    ptr_d = rx_valid ? (last ? '0 : ptr_q + 1'b1) : ptr_q;
    wrapped_d = wrapped_q | (rx_valid & last);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wren_q <= 1'b0;
      ferr_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wren_q <= wren_d;
      ferr_q <= ferr_d;
      wrapped_q <= wrapped_d;
    end
  end
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wren = wren_q;
  assign frame_err = ferr_q;
  assign wrapped = wrapped_q;
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: randomized 8N1 frames checked every cycle against a queue-based loader model
module tb_uart_ram_loader;
  localparam int cpb = 16;
  localparam int half = cpb / 2;
  localparam int depth = 4;
  localparam int lat = 3 + half + 9 * cpb;
  logic clk = 1'b0, rst_n, ser_rx;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic wren, frame_err, wrapped, busy;
  int cyc = 0, checks = 0, errors = 0, m_ptr = 0;
  int w_wr = 0, w_rd = 0, f_wr = 0, f_rd = 0;
  int w_addr[256], w_data[256], w_cyc[256], f_cyc[256];
  bit exp_wrapped = 0;
  uart_ram_loader #(.clock_rate(64), .baud_rate(4), .depth(depth)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ser_rx(ser_rx),
    .waddr(waddr),
    .wdata(wdata),
    .wren(wren),
    .frame_err(frame_err),
    .wrapped(wrapped),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic chk_lat(input string name, input int act, input int exp);
    checks++;
    if (act < exp - 1 || act > exp + 1) begin
      errors++;
      $display("FAIL %s: got cycle %0d expected %0d +-1", name, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    m_ptr = 0;
    wait_cyc(2);
  endtask
  // Bit boundaries may be shifted by up to +-3 cycles; the start edge and frame end stay nominal.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input bit jit, input bit expect_wr, input int rst_bit);
    int j[11];
    int fall;
    j[0] = 0;
    j[10] = 0;
    for (int k = 1; k < 10; k++) j[k] = jit ? int'($urandom_range(6)) - 3 : 0;
    fall = cyc;
    ser_rx = 1'b0;
    wait_cyc(cpb + j[1] - j[0]);
    for (int b = 0; b < 8; b++) begin
      ser_rx = d[b];
      if (b == rst_bit) begin
        wait_cyc(half);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        m_ptr = 0;
        wait_cyc(cpb - half - 1 + j[b+2] - j[b+1]);
      end else wait_cyc(cpb + j[b+2] - j[b+1]);
    end
    if (stop_low > 0) begin
      f_cyc[f_wr % 256] = fall + lat;
      f_wr++;
      ser_rx = 1'b0;
      wait_cyc(stop_low * cpb);
      ser_rx = 1'b1;
      wait_cyc(cpb);
    end else begin
      if (expect_wr) begin
        w_addr[w_wr % 256] = m_ptr;
        w_data[w_wr % 256] = int'(d);
        w_cyc[w_wr % 256] = fall + lat;
        w_wr++;
        m_ptr = (m_ptr + 1) % depth;
      end
      ser_rx = 1'b1;
      wait_cyc(cpb + j[10] - j[9]);
    end
  endtask
  task automatic drained();
    wait_cyc(cpb);
    chk("writes_drained", w_rd, w_wr);
    chk("ferrs_drained", f_rd, f_wr);
    chk("busy_idle", busy, 0);
  endtask
  initial begin
    ser_rx = 1'b1;
    rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          w_rd = w_wr;
          f_rd = f_wr;
          exp_wrapped = 0;
        end else begin
          chk("wren_ferr_exclusive", wren & frame_err, 0);
          if (wren) begin
            chk("wren_expected", w_rd < w_wr, 1);
            if (w_rd < w_wr) begin
              chk("waddr", waddr, w_addr[w_rd % 256]);
              chk("wdata", wdata, w_data[w_rd % 256]);
              chk_lat("wren_latency", cyc, w_cyc[w_rd % 256]);
              if (w_addr[w_rd % 256] == depth - 1) exp_wrapped = 1;
              w_rd++;
            end
          end else if (w_rd < w_wr) begin
            chk("wren_deadline", cyc <= w_cyc[w_rd % 256] + 1, 1);
            if (cyc > w_cyc[w_rd % 256] + 1) w_rd++;
          end
          if (frame_err) begin
            chk("ferr_expected", f_rd < f_wr, 1);
            if (f_rd < f_wr) begin
              chk_lat("ferr_latency", cyc, f_cyc[f_rd % 256]);
              f_rd++;
            end
          end else if (f_rd < f_wr) begin
            chk("ferr_deadline", cyc <= f_cyc[f_rd % 256] + 1, 1);
            if (cyc > f_cyc[f_rd % 256] + 1) f_rd++;
          end
          chk("wrapped", wrapped, exp_wrapped);
        end
      end
    join_none
    wait_cyc(3);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wren", wren, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(2);
    send_frame(8'hA5, 0, 0, 1, -1);
    drained();
    chk("single_waddr", waddr, 0);
    chk("single_wdata", wdata, 8'hA5);
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 0, 1, -1);
    drained();
    chk("b2b_wrapped", wrapped, 1);
    chk("b2b_waddr", waddr, 0);
    chk("b2b_wdata", wdata, 8'h05);
    do_reset();
    send_frame(8'h3C, 3, 0, 0, -1);
    wait_cyc(4);
    send_frame(8'h7E, 0, 0, 1, -1);
    drained();
    chk("ferr_then_waddr", waddr, 0);
    chk("ferr_then_wdata", wdata, 8'h7E);
    ser_rx = 1'b0;
    wait_cyc(5);
    ser_rx = 1'b1;
    wait_cyc(2 * cpb);
    chk("glitch_busy", busy, 0);
    send_frame(8'h11, 0, 0, 1, -1);
    drained();
    chk("glitch_ptr_waddr", waddr, 1);
    do_reset();
    send_frame(8'hF0, 0, 0, 0, 4);
    wait_cyc(4);
    send_frame(8'h55, 0, 0, 1, -1);
    drained();
    chk("rst_mid_waddr", waddr, 0);
    chk("rst_mid_wdata", wdata, 8'h55);
    do_reset();
    send_frame(8'h00, 0, 1, 1, -1);
    send_frame(8'hFF, 0, 1, 1, -1);
    drained();
    chk("jitter_waddr", waddr, 1);
    chk("jitter_wdata", wdata, 8'hFF);
    repeat (40) begin
      wait_cyc(int'($urandom_range(20)));
      send_frame(8'($urandom), ($urandom_range(7) == 0) ? int'($urandom_range(3, 1)) : 0,
                 1'($urandom), 1, -1);
    end
    drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
